stopwatch_ctrl: RTL and testbench
=================================

STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 Parameter: DEBOUNCE_CYCLES, default 1000000, consecutive stable synchronized samples required to accept a button level change (10 ms at 100 MHz).
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 btn_start  input  1  raw asynchronous start/stop push-button.
REQ-005 btn_lap  input  1  raw asynchronous lap/clear push-button.
REQ-006 time_in  input  16  live BCD time from the stopwatch counter (4 digits).
REQ-007 run  output  1  count enable to the stopwatch counter.
REQ-008 clear  output  1  one-cycle clear pulse to the stopwatch counter.
REQ-009 display_data  output  16  BCD value for the seven-segment controller.
REQ-010 lap_active  output  1  high while display_data shows the frozen lap value.

Function
REQ-011 Each button SHALL pass through a 2-flop synchronizer, then a debouncer that updates its debounced level only after DEBOUNCE_CYCLES consecutive synchronized samples differ from the current debounced level; the counter SHALL restart on any sample equal to the current level.
REQ-012 Each debouncer SHALL emit a one-cycle press pulse in the cycle its debounced level goes 0->1; releases produce no pulse; holding a button produces exactly one pulse.
REQ-013 FSM states: IDLE, RUNNING, LAP, PAUSED; state changes on the clock edge following the press-pulse cycle.
REQ-014 IDLE: run=0; start pulse -> RUNNING; lap pulse -> stay IDLE, clear=1 for one cycle.
REQ-015 RUNNING: run=1; start pulse -> PAUSED; lap pulse -> LAP and capture time_in into lap_reg on the same edge.
REQ-016 LAP: run=1 (counter keeps running), lap_active=1; lap pulse -> RUNNING; start pulse -> PAUSED (lap released).
REQ-017 PAUSED: run=0; start pulse -> RUNNING; lap pulse -> IDLE, clear=1 for one cycle.
REQ-018 run and lap_active SHALL be registered and decoded from current state (valid in the same cycle as the state); clear SHALL be registered, high exactly in the first cycle of the resulting state.
REQ-019 display_data SHALL equal lap_reg when lap_active=1, else time_in (combinational mux, zero latency from time_in).
REQ-020 Simultaneous start and lap pulses in one cycle: start SHALL win, the lap pulse is discarded.
REQ-021 lap_reg SHALL hold its value outside the RUNNING->LAP transition; a LAP->RUNNING->LAP sequence recaptures.

Reset
REQ-022 reset=1 SHALL force: state IDLE, run=0, clear=0, lap_active=0, lap_reg=16'h0000, synchronizers/debounced levels 0, debounce counters 0, no press pulses.
REQ-023 reset asserted mid-operation (any state, mid-debounce) SHALL take effect on the next edge; a button still held after reset SHALL produce one press pulse once it has been stable for DEBOUNCE_CYCLES.
REQ-024 The stopwatch counter reset SHALL be driven as (reset OR clear) by the enclosing top level.

Structure
REQ-025 Package stopwatch_pkg SHALL hold the state enum typedef (sw_state_t) and DEBOUNCE_CYCLES_DEFAULT constant.
REQ-026 Sub-module button_debounce (synchronizer + debouncer + press pulse, parameter DEBOUNCE_CYCLES) SHALL be instantiated twice.
REQ-027 Debounce counter width SHALL be $clog2(DEBOUNCE_CYCLES+1); no wrap permitted.

Verification (DEBOUNCE_CYCLES=4)
REQ-028 Reset, btn_start held high 8 cycles -> exactly one start pulse, run=1 from the state change onward, clear never asserted.
REQ-029 btn_start glitches high 3 cycles then low -> no pulse, state stays IDLE, run=0.
REQ-030 RUNNING with time_in=16'h1234, lap press -> lap_active=1, display_data=16'h1234 while time_in advances to 16'h1240; second lap press -> display_data follows time_in.
REQ-031 RUNNING, start press -> PAUSED (run=0); lap press -> IDLE with clear=1 for exactly one cycle.
REQ-032 Both buttons pressed same cycle in RUNNING -> PAUSED, lap_reg unchanged, lap_active=0.
REQ-033 reset asserted in LAP -> next cycle IDLE, run=0, lap_active=0, display_data=time_in, lap_reg=0.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch control block.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUNNING = 2'd1,
    LAP     = 2'd2,
    PAUSED  = 2'd3
  } sw_state_t;

  localparam int DEBOUNCE_CYCLES_DEFAULT = 1000000;

endpackage

// File: rtl/stopwatch_ctrl_if.sv
// Button, time and display signals between the stopwatch controller and its surroundings.
interface stopwatch_ctrl_if;
  logic        btn_start;
  logic        btn_lap;
  logic [15:0] time_in;
  logic        run;
  logic        clear;
  logic [15:0] display_data;
  logic        lap_active;

  modport master (
    output btn_start, btn_lap, time_in,
    input  run, clear, display_data, lap_active
  );

  modport slave (
    input  btn_start, btn_lap, time_in,
    output run, clear, display_data, lap_active
  );
endinterface

// File: rtl/stopwatch_ctrl_debounce.sv
// Two-flop synchronizer, consecutive-sample debouncer and rising-level press pulse.
import stopwatch_pkg::*;

module button_debounce #(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic press
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync_reg;
  logic          level_reg;
  logic [CW-1:0] cnt_reg;
  logic          press_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_reg  <= 2'b00;
      level_reg <= 1'b0;
      cnt_reg   <= '0;
      press_reg <= 1'b0;
    end else begin
      sync_reg  <= {sync_reg[0], btn};
      press_reg <= 1'b0;
      if (sync_reg[1] == level_reg) begin
        cnt_reg <= '0;
      end else if (cnt_reg == CNT_LAST) begin
        // Nth consecutive differing sample: accept the new level.
        level_reg <= sync_reg[1];
        cnt_reg   <= '0;
        press_reg <= sync_reg[1];
      end else begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

  assign press = press_reg;
endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch front-panel controller: debounced buttons drive run/lap/clear state machine.
import stopwatch_pkg::*;

module stopwatch_ctrl #(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic           clk,
  input  logic           reset,
  stopwatch_ctrl_if.slave sw
);
  logic [1:0] btn_raw;
  logic [1:0] press;

  assign btn_raw = {sw.btn_lap, sw.btn_start};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_btn
      button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
        .clk   (clk),
        .reset (reset),
        .btn   (btn_raw[gi]),
        .press (press[gi])
      );
    end
  endgenerate

  logic start_p;
  logic lap_p;
  assign start_p = press[0];
  assign lap_p   = press[1];

  sw_state_t   state_reg, state_next;
  logic        run_reg, lap_active_reg, clear_reg, clear_next, capture;
  logic [15:0] lap_reg;

  // Start is examined first in every state so it wins over a simultaneous lap.
  always_comb begin
    state_next = state_reg;
    clear_next = 1'b0;
    capture    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start_p)    state_next = RUNNING;
        else if (lap_p) clear_next = 1'b1;
      end
      RUNNING: begin
        if (start_p) begin
          state_next = PAUSED;
        end else if (lap_p) begin
          state_next = LAP;
          capture    = 1'b1;
        end
      end
      LAP: begin
        if (start_p)    state_next = PAUSED;
        else if (lap_p) state_next = RUNNING;
      end
      PAUSED: begin
        if (start_p) begin
          state_next = RUNNING;
        end else if (lap_p) begin
          state_next = IDLE;
          clear_next = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they line up with the state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      run_reg        <= 1'b0;
      lap_active_reg <= 1'b0;
      clear_reg      <= 1'b0;
      lap_reg        <= 16'h0000;
    end else begin
      state_reg      <= state_next;
      run_reg        <= (state_next == RUNNING) || (state_next == LAP);
      lap_active_reg <= (state_next == LAP);
      clear_reg      <= clear_next;
      if (capture) lap_reg <= sw.time_in;
    end
  end

  assign sw.run          = run_reg;
  assign sw.lap_active   = lap_active_reg;
  assign sw.clear        = clear_reg;
  assign sw.display_data = lap_active_reg ? lap_reg : sw.time_in;
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Scoreboard bench for stopwatch_ctrl with a short debounce window.
module tb_stopwatch_ctrl;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  stopwatch_ctrl_if sw ();

  stopwatch_ctrl #(.DEBOUNCE_CYCLES(4)) dut (
    .clk   (clk),
    .reset (reset),
    .sw    (sw)
  );

  typedef struct {
    string       tag;
    logic        run;
    logic        lap;
    logic [15:0] disp;
    int          clr;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  int   clear_cycles = 0;
  int   run_rises = 0;
  logic run_prev = 1'b0;

  always @(negedge clk) begin
    if (sw.clear === 1'b1) clear_cycles++;
    if (sw.run === 1'b1 && run_prev !== 1'b1) run_rises++;
    run_prev = sw.run;
  end

  // Reference model of the control behaviour: 0 idle, 1 running, 2 lap, 3 paused.
  int          mstate = 0;
  logic [15:0] mlap = 16'h0000;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] req);
    vectors++;
    if (obs !== req) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", tag, obs, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model(input bit s, input bit l, output int clr);
    clr = 0;
    case (mstate)
      0: if (s) mstate = 1; else if (l) clr = 1;
      1: if (s) mstate = 3; else if (l) begin mstate = 2; mlap = sw.time_in; end
      2: if (s) mstate = 3; else if (l) mstate = 1;
      3: if (s) mstate = 1; else if (l) begin mstate = 0; clr = 1; end
      default: mstate = 0;
    endcase
  endtask

  // One button transaction: hold the selected buttons, release, then compare.
  task automatic press(input string tag, input bit s, input bit l, input int hold);
    exp_t e;
    int   c0;
    int   clr;
    clr = 0;
    if (hold >= 4) model(s, l, clr);
    e.tag  = tag;
    e.run  = (mstate == 1) || (mstate == 2);
    e.lap  = (mstate == 2);
    e.disp = (mstate == 2) ? mlap : sw.time_in;
    e.clr  = clr;
    sb.push_back(e);
    c0 = clear_cycles;
    sw.btn_start = s;
    sw.btn_lap   = l;
    repeat (hold) step();
    sw.btn_start = 1'b0;
    sw.btn_lap   = 1'b0;
    repeat (10) step();
    e = sb.pop_front();
    check({e.tag, ".run"}, 32'(sw.run), 32'(e.run));
    check({e.tag, ".lap_active"}, 32'(sw.lap_active), 32'(e.lap));
    check({e.tag, ".display"}, 32'(sw.display_data), 32'(e.disp));
    check({e.tag, ".clear_cycles"}, 32'(clear_cycles - c0), 32'(e.clr));
    $display("txn %s: state=%0d run=%b lap=%b disp=%h", e.tag, mstate, sw.run, sw.lap_active, sw.display_data);
  endtask

  initial begin
    int r0;
    reset        = 1'b1;
    sw.btn_start = 1'b0;
    sw.btn_lap   = 1'b0;
    sw.time_in   = 16'h0042;
    repeat (3) step();
    check("reset.run", 32'(sw.run), 32'd0);
    check("reset.clear", 32'(sw.clear), 32'd0);
    check("reset.lap_active", 32'(sw.lap_active), 32'd0);
    check("reset.display", 32'(sw.display_data), 32'h0042);
    reset = 1'b0;
    step();

    press("glitch", 1'b1, 1'b0, 3);
    r0 = run_rises;
    press("start_idle", 1'b1, 1'b0, 8);
    check("start_idle.run_rises", 32'(run_rises - r0), 32'd1);

    sw.time_in = 16'h1234;
    press("lap_capture", 1'b0, 1'b1, 8);
    sw.time_in = 16'h1240;
    step();
    check("lap_frozen.display", 32'(sw.display_data), 32'h1234);
    check("lap_frozen.run", 32'(sw.run), 32'd1);
    press("lap_release", 1'b0, 1'b1, 8);
    sw.time_in = 16'h1241;
    #1;
    check("lap_follow.display", 32'(sw.display_data), 32'h1241);

    press("pause", 1'b1, 1'b0, 8);
    press("clear_paused", 1'b0, 1'b1, 8);
    press("clear_idle", 1'b0, 1'b1, 8);

    press("restart", 1'b1, 1'b0, 8);
    sw.time_in = 16'h0555;
    press("lap2", 1'b0, 1'b1, 8);
    sw.time_in = 16'h0600;
    press("unlap2", 1'b0, 1'b1, 8);
    sw.time_in = 16'h0610;
    press("both", 1'b1, 1'b1, 8);
    check("both.lap_reg", 32'(dut.lap_reg), 32'h0555);
    press("resume", 1'b1, 1'b0, 8);
    sw.time_in = 16'h0777;
    press("lap3", 1'b0, 1'b1, 8);
    sw.time_in = 16'h0780;

    reset = 1'b1;
    step();
    mstate = 0;
    mlap   = 16'h0000;
    check("rst_lap.run", 32'(sw.run), 32'd0);
    check("rst_lap.lap_active", 32'(sw.lap_active), 32'd0);
    check("rst_lap.display", 32'(sw.display_data), 32'h0780);
    check("rst_lap.lap_reg", 32'(dut.lap_reg), 32'h0000);
    reset = 1'b0;
    step();

    // Button held across a reset must yield exactly one press afterwards.
    r0 = run_rises;
    sw.btn_start = 1'b1;
    repeat (4) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    repeat (10) step();
    sw.btn_start = 1'b0;
    repeat (10) step();
    check("held_reset.run", 32'(sw.run), 32'd1);
    check("held_reset.run_rises", 32'(run_rises - r0), 32'd1);
    $display("txn held_reset: run=%b", sw.run);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
